control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer, parametrised in word, field and PC width.
//  Fetches 4-field instructions (opcode, addrA, addrB, addrW) over a req/valid
//  instruction-memory port and reads two register-file operands.
//  Resolves HALT/JMP/BEQZ locally, hands all other opcodes to an external ALU via
//  start/done, and writes the result back to register addrW.
// PARAMETERS
//  WORD_W   20  instruction and data word width; must be >= 4*FIELD_W
//  FIELD_W  5   opcode and register-address field width
//  PC_W     5   program counter width; instruction memory depth is 2**PC_W
//  CNT_W    16  retired-instruction counter width
//  OP_HALT  31  opcode: stop and enter HALT
//  OP_JMP   30  opcode: pc <= addrW
//  OP_BEQZ  29  opcode: if reg[addrA]==0 then pc <= addrW, else pc+1
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  run         in   1        start request, sampled only in IDLE
//  halted      out  1        high while in HALT
//  pc          out  PC_W     current program counter
//  instr_count out  CNT_W    retired-instruction count, saturating
//  imem_req    out  1        instruction read request
//  imem_addr   out  PC_W     instruction address (= pc)
//  imem_valid  in   1        imem_rdata valid this cycle
//  imem_rdata  in   WORD_W   instruction word
//  rf_raddr_a  out  FIELD_W  register-file read address A
//  rf_raddr_b  out  FIELD_W  register-file read address B
//  rf_rdata_a  in   WORD_W   combinational read data A
//  rf_rdata_b  in   WORD_W   combinational read data B
//  alu_op      out  FIELD_W  opcode presented to the ALU
//  alu_a/alu_b out  WORD_W   latched operands A and B
//  alu_start   out  1        one-cycle ALU start pulse
//  alu_done    in   1        ALU result valid
//  alu_result  in   WORD_W   ALU result
//  rf_we       out  1        register-file write enable, one cycle
//  rf_waddr    out  FIELD_W  write address (addrW)
//  rf_wdata    out  WORD_W   write data
// BEHAVIOUR
//  Field layout: op=[F-1:0], A=[2F-1:F], B=[3F-1:2F], W=[4F-1:3F]; bits above 4F are ignored.
//  Reset values: state=IDLE; pc=0; instr_count=0; all strobes (imem_req, alu_start,
//   rf_we, halted) low; all latched regs 0. Reset in any state aborts the in-flight instruction.
//  IDLE:   run=1 -> FETCH.
//  FETCH:  imem_req=1, imem_addr=pc held stable until imem_valid.
//          On imem_valid: latch instruction -> DECODE. imem_valid is accepted in the same cycle as req.
//  DECODE: latch fields; rf_raddr_a/b driven from the latched A/B fields from this cycle on -> READ.
//  READ:   latch alu_a<=rf_rdata_a, alu_b<=rf_rdata_b. Then by opcode:
//          HALT -> HALT.
//          JMP  -> pc<=W[PC_W-1:0], retire, FETCH.
//          BEQZ -> pc<=(rf_rdata_a==0)?W[PC_W-1:0]:pc+1, retire, FETCH.
//          else -> EXEC.
//  EXEC:   alu_start=1 on the entry cycle only; wait for alu_done.
//          alu_done is ignored in the start cycle. On done: latch alu_result -> WRITE.
//  WRITE:  rf_we=1 for exactly one cycle, rf_waddr=W, rf_wdata=latched result;
//          pc<=pc+1, retire -> FETCH.
//  HALT:   halted=1; held until rst; run is ignored.
//  Retire: instr_count+1, saturating at 2**CNT_W-1. HALT does not retire.
//  pc+1 wraps modulo 2**PC_W (31 -> 0 at default).
//  imem_valid outside FETCH and alu_done outside EXEC are ignored.
//  Latency: ALU instruction 6 cycles minimum (1-cycle imem, 1-cycle ALU);
//   JMP/BEQZ 3 cycles minimum.
// TESTING
//  1. rst, run=1, imem returns {W=3,B=2,A=1,op=1}, rf a=5/b=7, ALU done next cycle with 12
//     -> alu_a=5, alu_b=7, rf_we one cycle with waddr=3/wdata=12; pc 0->1; instr_count=1; 6 cycles.
//  2. pc=0, op=OP_JMP, W=17 -> no alu_start and no rf_we; next imem_addr=17.
//  3. op=OP_BEQZ, W=9: rf_rdata_a=0 -> pc=9; rf_rdata_a=4 -> pc=pc+1.
//  4. ALU instruction at pc=31 -> pc wraps to 0. imem_valid delayed 3 cycles
//     -> imem_req and imem_addr held stable throughout.
//  5. op=OP_HALT -> halted=1; run pulses ignored; instr_count unchanged; rst -> IDLE, pc=0, halted=0.
//  6. rst asserted mid-EXEC, then alu_done arrives after reset -> no rf_we, outputs at reset values.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: fetches 4-field instructions, resolves
// HALT/JMP/BEQZ locally and hands every other opcode to an external ALU.
module control_sequencer #(
  parameter int unsigned WORD_W  = 20,
  parameter int unsigned FIELD_W = 5,
  parameter int unsigned PC_W    = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned OP_HALT = 31,
  parameter int unsigned OP_JMP  = 30,
  parameter int unsigned OP_BEQZ = 29
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   instr_count,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [WORD_W-1:0]  imem_rdata,
  output logic [FIELD_W-1:0] rf_raddr_a,
  output logic [FIELD_W-1:0] rf_raddr_b,
  input  logic [WORD_W-1:0]  rf_rdata_a,
  input  logic [WORD_W-1:0]  rf_rdata_b,
  output logic [FIELD_W-1:0] alu_op,
  output logic [WORD_W-1:0]  alu_a,
  output logic [WORD_W-1:0]  alu_b,
  output logic               alu_start,
  input  logic               alu_done,
  input  logic [WORD_W-1:0]  alu_result,
  output logic               rf_we,
  output logic [FIELD_W-1:0] rf_waddr,
  output logic [WORD_W-1:0]  rf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_START, S_WAIT, S_WRITE, S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            retire;
  logic            fetch_accept;

  // Instruction word bits above the four fields carry no meaning.
  if (WORD_W > 4 * FIELD_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^imem_rdata[WORD_W-1:4*FIELD_W];
  end

  assign imem_addr    = pc;
  assign fetch_accept = (state == S_FETCH) && imem_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, next pc and retire strobe.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    retire    = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_READ;
      S_READ: begin
        if (alu_op == FIELD_W'(OP_HALT)) begin
          state_nxt = S_HALT;
        end else if (alu_op == FIELD_W'(OP_JMP)) begin
          pc_nxt    = PC_W'(rf_waddr);
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (alu_op == FIELD_W'(OP_BEQZ)) begin
          pc_nxt    = (rf_rdata_a == '0) ? PC_W'(rf_waddr) : pc + PC_W'(1);
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   if (alu_done) state_nxt = S_WRITE;
      S_WRITE: begin
        pc_nxt    = pc + PC_W'(1);
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered datapath and strobes; strobes decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instr_count <= '0;
      imem_req    <= 1'b0;
      alu_start   <= 1'b0;
      rf_we       <= 1'b0;
      halted      <= 1'b0;
      alu_op      <= '0;
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      rf_waddr    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rf_wdata    <= '0;
    end else begin
      pc        <= pc_nxt;
      imem_req  <= (state_nxt == S_FETCH);
      alu_start <= (state_nxt == S_START);
      rf_we     <= (state_nxt == S_WRITE);
      halted    <= (state_nxt == S_HALT);
      if (retire && (instr_count != '1)) instr_count <= instr_count + CNT_W'(1);
      if (fetch_accept) begin
        alu_op     <= imem_rdata[0 +: FIELD_W];
        rf_raddr_a <= imem_rdata[FIELD_W +: FIELD_W];
        rf_raddr_b <= imem_rdata[2*FIELD_W +: FIELD_W];
        rf_waddr   <= imem_rdata[3*FIELD_W +: FIELD_W];
      end
      if (state == S_READ) begin
        alu_a <= rf_rdata_a;
        alu_b <= rf_rdata_b;
      end
      if ((state == S_WAIT) && alu_done) rf_wdata <= alu_result;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus a random program checked
// against an instruction-level model of the sequencer.
module tb_control_sequencer;

  localparam int unsigned OP_HALT = 31;
  localparam int unsigned OP_JMP  = 30;
  localparam int unsigned OP_BEQZ = 29;

  logic        clk = 1'b0;
  logic        rst, run, halted, imem_req, imem_valid, alu_start, alu_done, rf_we;
  logic [4:0]  pc, imem_addr, rf_raddr_a, rf_raddr_b, alu_op, rf_waddr;
  logic [15:0] instr_count;
  logic [19:0] imem_rdata, rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_result, rf_wdata;

  logic [19:0] imem   [32];
  logic [19:0] rf_mem [32];
  logic [19:0] ref_rf [32];
  logic [4:0]  ref_pc;
  logic [15:0] ref_count;
  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .halted(halted), .pc(pc), .instr_count(instr_count),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Combinational register file seen by the DUT.
  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];

  function automatic logic [19:0] alu_fn(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b);
    return (op == 5'd1) ? a + b : a ^ (b + 20'(op));
  endfunction

  function automatic logic [19:0] mk(input int op, input int a, input int b, input int w);
    return {5'(w), 5'(b), 5'(a), 5'(op)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_valid = 1'b0; alu_done = 1'b0;
    imem_rdata = '0; alu_result = '0;
    step(); step();
    rst = 1'b0;
    step();
    ref_pc = '0; ref_count = '0;
  endtask

  task automatic start_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic sync_rf();
    for (int i = 0; i < 32; i++) ref_rf[i] = rf_mem[i];
  endtask

  // Drives one instruction from its FETCH cycle to the next FETCH (or HALT), checking against the model.
  task automatic exec_one(input int lat_imem, input int lat_alu, input bit early_done);
    logic [19:0] word, va, vb, res;
    logic [4:0]  op, a, w, exp_pc;
    int cyc, budget;
    word = imem[ref_pc];
    op = word[4:0]; a = word[9:5]; w = word[19:15];
    va = ref_rf[a]; vb = ref_rf[word[14:10]];
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ref_pc) begin
      errors++; $display("FAIL fetch_req: req=%b addr=%0d, want req=1 addr=%0d", imem_req, imem_addr, ref_pc);
    end
    cyc = 0;
    repeat (lat_imem) begin
      imem_valid = 1'b0; imem_rdata = 20'($urandom); alu_done = 1'($urandom);
      step(); cyc++;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== ref_pc) begin
        errors++; $display("FAIL fetch_stall: req=%b addr=%0d, want req=1 addr=%0d", imem_req, imem_addr, ref_pc);
      end
    end
    imem_valid = 1'b1; imem_rdata = word; alu_done = 1'b0;
    step(); cyc++;
    budget = 0;
    while (!(alu_start === 1'b1 || imem_req === 1'b1 || halted === 1'b1) && budget < 10) begin
      imem_valid = 1'($urandom); imem_rdata = 20'($urandom); alu_done = 1'($urandom);
      step(); cyc++; budget++;
    end
    imem_valid = 1'b0; alu_done = 1'b0;
    checks++;
    if (budget >= 10) begin
      errors++; $display("FAIL decode_timeout: no start/fetch/halt within %0d cycles", budget);
      return;
    end
    if (op == 5'(OP_HALT)) begin
      if (halted !== 1'b1 || alu_start !== 1'b0 || imem_req !== 1'b0 || cyc != lat_imem + 3) begin
        errors++; $display("FAIL halt_entry: halted=%b start=%b req=%b cyc=%0d, want 1/0/0 cyc=%0d", halted, alu_start, imem_req, cyc, lat_imem + 3);
      end
      return;
    end
    if (op == 5'(OP_JMP) || op == 5'(OP_BEQZ)) begin
      exp_pc = (op == 5'(OP_JMP) || va == '0) ? w : ref_pc + 5'd1;
      if (alu_start !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b0 || cyc != lat_imem + 3) begin
        errors++; $display("FAIL branch_flow: start=%b we=%b halted=%b cyc=%0d, want 0/0/0 cyc=%0d", alu_start, rf_we, halted, cyc, lat_imem + 3);
      end
    end else begin
      exp_pc = ref_pc + 5'd1;
      if (alu_start !== 1'b1 || cyc != lat_imem + 3 || alu_op !== op || alu_a !== va || alu_b !== vb) begin
        errors++; $display("FAIL alu_issue: start=%b cyc=%0d op=%0d a=%0h b=%0h, want 1 cyc=%0d op=%0d a=%0h b=%0h", alu_start, cyc, alu_op, alu_a, alu_b, lat_imem + 3, op, va, vb);
      end
      alu_done = early_done; alu_result = 20'($urandom);
      step(); cyc++;
      alu_done = 1'b0;
      checks++;
      if (alu_start !== 1'b0) begin
        errors++; $display("FAIL alu_start_pulse: start=%b, want 0", alu_start);
      end
      repeat (lat_alu) begin
        imem_valid = 1'($urandom); step(); cyc++;
      end
      imem_valid = 1'b0;
      alu_done = 1'b1; alu_result = alu_fn(alu_op, alu_a, alu_b);
      step(); cyc++;
      alu_done = 1'b0;
      res = alu_fn(op, va, vb);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== w || rf_wdata !== res) begin
        errors++; $display("FAIL writeback: we=%b waddr=%0d wdata=%0h, want 1 %0d %0h", rf_we, rf_waddr, rf_wdata, w, res);
      end
      rf_mem[rf_waddr] = rf_wdata;
      ref_rf[w] = res;
      step(); cyc++;
      checks++;
      if (rf_we !== 1'b0 || imem_req !== 1'b1 || cyc != lat_imem + lat_alu + 6) begin
        errors++; $display("FAIL alu_latency: we=%b req=%b cyc=%0d, want 0 1 cyc=%0d", rf_we, imem_req, cyc, lat_imem + lat_alu + 6);
      end
    end
    ref_pc = exp_pc;
    if (ref_count != 16'hFFFF) ref_count++;
    checks++;
    if (pc !== ref_pc || imem_addr !== ref_pc || instr_count !== ref_count) begin
      errors++; $display("FAIL retire: pc=%0d addr=%0d count=%0d, want pc=%0d count=%0d", pc, imem_addr, instr_count, ref_pc, ref_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 5'd0 || instr_count !== 16'd0 || imem_req !== 1'b0 || alu_start !== 1'b0 || rf_we !== 1'b0 ||
        halted !== 1'b0 || alu_a !== 20'd0 || alu_b !== 20'd0 || rf_wdata !== 20'd0 || rf_waddr !== 5'd0) begin
      errors++; $display("FAIL reset_values: pc=%0d cnt=%0d req=%b start=%b we=%b halted=%b a=%0h b=%0h wd=%0h, want all 0",
                         pc, instr_count, imem_req, alu_start, rf_we, halted, alu_a, alu_b, rf_wdata);
    end
    step(); step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_without_run: req=%b, want 0", imem_req);
    end
  endtask

  task automatic test_alu_basic();
    do_reset();
    imem[0] = mk(1, 1, 2, 3); rf_mem[1] = 20'd5; rf_mem[2] = 20'd7; sync_rf();
    start_run();
    exec_one(0, 0, 1'b0);
    checks++;
    if (ref_rf[3] !== 20'd12 || rf_mem[3] !== 20'd12) begin
      errors++; $display("FAIL alu_basic_result: rf3=%0d, want 12", rf_mem[3]);
    end
  endtask

  task automatic test_jmp();
    do_reset();
    imem[0] = mk(OP_JMP, 4, 6, 17); imem[17] = mk(OP_JMP, 0, 0, 2); sync_rf();
    start_run();
    exec_one(0, 0, 1'b0);
    exec_one(1, 0, 1'b0);
  endtask

  task automatic test_beqz();
    do_reset();
    imem[0] = mk(OP_BEQZ, 2, 0, 9); imem[9] = mk(OP_BEQZ, 3, 0, 20);
    rf_mem[2] = 20'd0; rf_mem[3] = 20'd4; sync_rf();
    start_run();
    exec_one(0, 0, 1'b0);
    exec_one(0, 0, 1'b0);
    checks++;
    if (pc !== 5'd10) begin
      errors++; $display("FAIL beqz_not_taken: pc=%0d, want 10", pc);
    end
  endtask

  task automatic test_wrap_stall();
    do_reset();
    imem[0] = mk(OP_JMP, 0, 0, 31); imem[31] = mk(2, 4, 5, 6);
    rf_mem[4] = 20'h12345; rf_mem[5] = 20'h00F0F; sync_rf();
    start_run();
    exec_one(0, 0, 1'b0);
    exec_one(3, 2, 1'b1);
    checks++;
    if (pc !== 5'd0) begin
      errors++; $display("FAIL pc_wrap: pc=%0d, want 0", pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    imem[0] = mk(OP_JMP, 0, 0, 5); imem[5] = mk(OP_HALT, 1, 2, 3); sync_rf();
    start_run();
    exec_one(0, 0, 1'b0);
    exec_one(1, 0, 1'b0);
    repeat (4) begin
      run = 1'b1; imem_valid = 1'b1; step(); run = 1'b0; imem_valid = 1'b0; step();
    end
    checks++;
    if (halted !== 1'b1 || instr_count !== 16'd1 || imem_req !== 1'b0 || pc !== 5'd5) begin
      errors++; $display("FAIL halt_hold: halted=%b cnt=%0d req=%b pc=%0d, want 1 1 0 5", halted, instr_count, imem_req, pc);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== 5'd0 || instr_count !== 16'd0) begin
      errors++; $display("FAIL halt_reset: halted=%b pc=%0d cnt=%0d, want 0 0 0", halted, pc, instr_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    int budget;
    bit saw_we;
    do_reset();
    imem[0] = mk(3, 1, 2, 4); rf_mem[1] = 20'd9; rf_mem[2] = 20'd11; sync_rf();
    start_run();
    imem_valid = 1'b1; imem_rdata = imem[0]; step(); imem_valid = 1'b0;
    budget = 0;
    while (alu_start !== 1'b1 && budget < 10) begin step(); budget++; end
    checks++;
    if (budget >= 10) begin
      errors++; $display("FAIL abort_setup: alu_start never seen");
    end
    step();
    rst = 1'b1; step(); rst = 1'b0;
    alu_done = 1'b1; alu_result = 20'h55555;
    saw_we = 1'b0;
    repeat (3) begin step(); alu_done = 1'b0; if (rf_we === 1'b1) saw_we = 1'b1; end
    checks++;
    if (saw_we || pc !== 5'd0 || instr_count !== 16'd0 || imem_req !== 1'b0 || alu_start !== 1'b0 ||
        alu_a !== 20'd0 || rf_wdata !== 20'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL abort_exec: we_seen=%b pc=%0d cnt=%0d req=%b start=%b a=%0h wd=%0h, want all 0",
                         saw_we, pc, instr_count, imem_req, alu_start, alu_a, rf_wdata);
    end
  endtask

  task automatic test_random_program();
    int r;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)      imem[i] = mk(OP_JMP, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      else if (r < 4) imem[i] = mk(OP_BEQZ, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      else            imem[i] = mk(int'($urandom_range(0, 28)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      rf_mem[i] = ($urandom_range(0, 2) == 0) ? 20'd0 : 20'($urandom);
    end
    sync_rf();
    start_run();
    for (int n = 0; n < 200; n++)
      exec_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf_mem[i] !== ref_rf[i]) begin
        errors++; $display("FAIL rand_regfile[%0d]: got %0h, want %0h", i, rf_mem[i], ref_rf[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin imem[i] = '0; rf_mem[i] = '0; end
    test_reset();
    test_alu_basic();
    test_jmp();
    test_beqz();
    test_wrap_stall();
    test_halt();
    test_reset_mid_exec();
    test_random_program();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
